risc_lsu: RTL
=============

// Module: risc_lsu
// PURPOSE
//  Load/store unit downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data.
//  It runs one request/acknowledge transaction per load or store on the 32-bit data bus.
//  It stalls the single-cycle core until the transaction completes, then returns sign- or zero-extended load data.
//  It flags misaligned or illegal accesses and bus timeouts without issuing or without completing a bus cycle.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ without bus_ack before abort; legal range 1..255 (8-bit counter)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  mem_read     in   1   load request from the decoder
//  mem_write    in   1   store request from the decoder
//  funct3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr         in   32  effective address (ALU result)
//  wdata        in   32  store data (rs2)
//  stall        out  1   hold PC and register writes
//  load_data    out  32  extended load result, valid while load_valid=1
//  load_valid   out  1   one-cycle pulse, load complete
//  lsu_err      out  1   one-cycle pulse: misaligned, illegal funct3, read&write together, or timeout
//  bus_req      out  1   bus request, registered
//  bus_we       out  1   1=write
//  bus_addr     out  32  word-aligned address ({addr[31:2],2'b00})
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_ack      in   1   bus completion, sampled only in REQ
//  bus_rdata    in   32  read data, valid with bus_ack
// BEHAVIOUR
//  Reset values
//   - State: IDLE.
//   - Outputs: all 0, including bus_req, stall, load_valid, lsu_err and load_data.
//  FSM states: IDLE, REQ, DONE.
//  IDLE
//   - Error check: mem_read&mem_write, illegal funct3 (load 011/110/111; store >=011), H with addr[0]=1,
//     or W with addr[1:0]!=0.
//   - On error: lsu_err=1 for that cycle, stall=0, no bus cycle, stay IDLE.
//   - On a legal request: stall=1 (combinational); latch addr, funct3, we, be and wdata.
//     Next state REQ; clear the timeout counter.
//  REQ
//   - bus_req=1 and all bus_* outputs held stable; stall=1.
//   - bus_ack=1: capture bus_rdata and go to DONE. Ack in the first REQ cycle is legal (1-cycle bus).
//   - No ack: counter increments each cycle. When it reaches TIMEOUT_CYCLES, drop bus_req and go to DONE
//     with the error flag set.
//  DONE (exactly one cycle)
//   - stall=0; bus_req=0.
//   - Load: load_valid=1 with load_data.
//   - Timeout: lsu_err=1, load_valid=0, load_data=0.
//   - mem_read/mem_write are ignored: still the same instruction. Always returns to IDLE.
//  Latency: load or store = 1 + ack_delay + 1 cycles of instruction occupancy; stall is high for all but the last cycle.
//  Byte enables
//   - B: 1<<addr[1:0].
//   - H: 0011 when addr[1]=0, 1100 when addr[1]=1.
//   - W: 1111.
//   - Loads drive the same be.
//  Store data: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
//  Load extraction: select the lane by the latched addr[1:0].
//   - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//  Boundaries
//   - bus_ack outside REQ is ignored.
//   - load_data holds its value until the next completion.
//   - The timeout counter saturates and does not wrap.
//   - Address arithmetic takes no carry beyond bit 31.
//  Reset mid-transaction
//   - bus_req, stall and pulses drop asynchronously; state returns to IDLE.
//   - A late bus_ack after reset is ignored.
// TESTING
//  1. LW addr=0x100; ack 3 cycles after bus_req, rdata=0xDEADBEEF
//     -> bus_addr=0x100, be=1111; stall 4 cycles; load_valid with 0xDEADBEEF.
//  2. LB addr=0x103, rdata=0x80123456 -> be=1000, load_data=0xFFFFFF80.
//     LBU at the same address -> 0x00000080.
//  3. SH addr=0x102, wdata=0x00001234 -> bus_we=1, be=1100, bus_wdata=0x12341234; no load_valid.
//  4. LW addr=0x101, or mem_read&mem_write together -> lsu_err pulse, stall=0, bus_req never asserted.
//  5. TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then DONE with lsu_err=1, load_data=0, stall drops.
//  6. rst asserted mid-REQ -> bus_req=0 immediately; ack one cycle later ignored; next LW completes normally.

Source files
------------

// File: rtl/risc_lsu.sv
// Load/store unit: one req/ack bus transaction per load or store. It stalls the core until the transaction
// completes, then returns extended load data or flags an error.
module risc_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [7:0]  tcnt;
  logic [1:0]  lane;
  logic [2:0]  f3_q;
  logic        timeout_q;
  logic        req_any, illegal, misaligned, req_err, req_ok, tmo_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ext_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request decode and checking (only meaningful in IDLE)
  always_comb begin
    req_any    = mem_read | mem_write;
    illegal    = mem_write ? (funct3 >= 3'b011)
                           : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    req_err    = req_any && ((mem_read && mem_write) || illegal || misaligned);
    req_ok     = req_any && !req_err;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the latched offset and size
  always_comb begin
    byte_sel = 8'(bus_rdata >> {lane, 3'b000});
    half_sel = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ext_c = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_c = {24'h0, byte_sel};
      3'b001:  ext_c = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_c = {16'h0, half_sel};
      default: ext_c = bus_rdata;
    endcase
  end

  // Widened compare so TIMEOUT_CYCLES=255 cannot overflow the counter arithmetic
  assign tmo_hit = ({1'b0, tcnt} + 9'd1) >= TMO_LIMIT;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    load_valid = 1'b0;
    lsu_err    = 1'b0;
    case (state)
      IDLE: begin
        stall   = req_ok;
        lsu_err = req_err;
        if (req_ok) state_next = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || tmo_hit) state_next = DONE;
      end
      DONE: begin
        load_valid = !bus_we && !timeout_q;
        lsu_err    = timeout_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      load_data <= '0;
      lane      <= '0;
      f3_q      <= '0;
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_next;
      bus_req <= (state_next == REQ);
      case (state)
        IDLE: if (req_ok) begin
          bus_we    <= mem_write;
          bus_addr  <= {addr[31:2], 2'b00};
          bus_be    <= be_c;
          bus_wdata <= wdata_c;
          lane      <= addr[1:0];
          f3_q      <= funct3;
          tcnt      <= '0;
          timeout_q <= 1'b0;
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) load_data <= ext_c;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            load_data <= '0;
          end
          if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
